// File: rtl/multi_reg_addr_sequencer_pkg.sv
// Shared definitions for the multi-register address sequencer: op encoding,
// architectural register numbers and sequencer states.
package multi_reg_addr_sequencer_pkg;

  typedef enum logic [1:0] {
    MR_PUSH = 2'd0,
    MR_POP  = 2'd1,
    MR_STM  = 2'd2,
    MR_LDM  = 2'd3
  } mr_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2
  } seq_state_e;

  localparam int SP_REG_NUM = 13;
  localparam int LR_REG_NUM = 14;
  localparam int PC_REG_NUM = 15;

endpackage

// File: rtl/multi_reg_addr_sequencer_ffs.sv
// Lowest-set-bit finder: index of the least significant 1 plus an any-set flag.
module find_first_set #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]         vec,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     any
);

  // Scan from the top down so the lowest set bit is the last to win
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = ($clog2(WIDTH))'(i);
        any = 1'b1;
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/multi_reg_addr_sequencer.sv
// Expands PUSH/POP/STM/LDM into one beat per transferred register, in
// ascending register order, followed by a single base-writeback cycle.
module multi_reg_addr_sequencer
  import multi_reg_addr_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH     = 4,
  parameter int REG_LIST_WIDTH = 8,
  parameter int OFF_WIDTH      = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      instr_valid_i,
  output logic                      instr_ready_o,
  input  mr_op_e                    op_i,
  input  logic [REG_LIST_WIDTH-1:0] reg_list_i,
  input  logic                      extra_reg_i,
  input  logic [ADDR_WIDTH-1:0]     base_reg_i,
  input  logic                      flush_i,
  output logic                      beat_valid_o,
  input  logic                      beat_ready_i,
  output logic [ADDR_WIDTH-1:0]     beat_reg_addr_o,
  output logic [ADDR_WIDTH-1:0]     beat_base_addr_o,
  output logic [OFF_WIDTH-1:0]      beat_offset_o,
  output logic                      beat_is_load_o,
  output logic                      beat_last_o,
  output logic                      wb_valid_o,
  output logic [ADDR_WIDTH-1:0]     wb_reg_o,
  output logic [OFF_WIDTH-1:0]      wb_offset_o,
  output logic                      busy_o
);

  localparam int MASK_W = 2**ADDR_WIDTH;

  seq_state_e              state_r;
  mr_op_e                  op_r;
  logic [MASK_W-1:0]       mask_r;
  logic [ADDR_WIDTH-1:0]   n_r;
  logic [ADDR_WIDTH-1:0]   k_r;
  logic [ADDR_WIDTH-1:0]   base_r;
  logic                    base_in_mask_r;

  logic [MASK_W-1:0]       new_mask_s;
  logic [ADDR_WIDTH-1:0]   new_cnt_s;
  logic [ADDR_WIDTH-1:0]   new_base_s;
  logic [MASK_W-1:0]       mask_nxt_s;
  logic [ADDR_WIDTH-1:0]   ffs_idx_s;
  logic                    ffs_any_s;
  logic [ADDR_WIDTH-1:0]   k_inc_s;

  // Byte offset of beat k: PUSH counts up from -4*N, everything else from 0
  function automatic logic [OFF_WIDTH-1:0] beat_off(input mr_op_e op,
                                                    input logic [ADDR_WIDTH-1:0] n,
                                                    input logic [ADDR_WIDTH-1:0] k);
    logic [OFF_WIDTH-1:0] kx;
    logic [OFF_WIDTH-1:0] nx;
    kx = OFF_WIDTH'(k) << 2;
    nx = OFF_WIDTH'(n) << 2;
    return (op == MR_PUSH) ? (kx - nx) : kx;
  endfunction

  function automatic logic [OFF_WIDTH-1:0] wb_off(input mr_op_e op,
                                                  input logic [ADDR_WIDTH-1:0] n);
    logic [OFF_WIDTH-1:0] nx;
    nx = OFF_WIDTH'(n) << 2;
    return (op == MR_PUSH) ? (OFF_WIDTH'(0) - nx) : nx;
  endfunction

  // Register mask, transfer count and base for the instruction on the inputs
  always_comb begin
    new_mask_s                        = '0;
    new_mask_s[REG_LIST_WIDTH-1:0]    = reg_list_i;
    new_mask_s[LR_REG_NUM]            = (op_i == MR_PUSH) && extra_reg_i;
    new_mask_s[PC_REG_NUM]            = (op_i == MR_POP) && extra_reg_i;
    new_cnt_s                         = '0;
    for (int i = 0; i < MASK_W; i++) begin
      new_cnt_s = new_cnt_s + ADDR_WIDTH'(new_mask_s[i]);
    end
    new_base_s = ((op_i == MR_PUSH) || (op_i == MR_POP)) ? ADDR_WIDTH'(SP_REG_NUM) : base_reg_i;
  end

  // Mask the next beat is picked from: fresh in IDLE, minus the issued bit in ISSUE
  always_comb begin
    k_inc_s = k_r + ADDR_WIDTH'(1);
    if (state_r == S_IDLE) begin
      mask_nxt_s = new_mask_s;
    end else if (state_r == S_ISSUE) begin
      mask_nxt_s = mask_r & ~(MASK_W'(1) << beat_reg_addr_o);
    end else begin
      mask_nxt_s = mask_r;
    end
  end

  find_first_set #(.WIDTH(MASK_W)) u_ffs (
    .vec (mask_nxt_s),
    .idx (ffs_idx_s),
    .any (ffs_any_s)
  );

  // Sequencer FSM; every output is registered here
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r          <= S_IDLE;
      op_r             <= MR_PUSH;
      mask_r           <= '0;
      n_r              <= '0;
      k_r              <= '0;
      base_r           <= '0;
      base_in_mask_r   <= 1'b0;
      instr_ready_o    <= 1'b1;
      beat_valid_o     <= 1'b0;
      beat_reg_addr_o  <= '0;
      beat_base_addr_o <= '0;
      beat_offset_o    <= '0;
      beat_is_load_o   <= 1'b0;
      beat_last_o      <= 1'b0;
      wb_valid_o       <= 1'b0;
      wb_reg_o         <= '0;
      wb_offset_o      <= '0;
      busy_o           <= 1'b0;
    end else if (flush_i) begin
      state_r       <= S_IDLE;
      beat_valid_o  <= 1'b0;
      wb_valid_o    <= 1'b0;
      instr_ready_o <= 1'b1;
      busy_o        <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          wb_valid_o <= 1'b0;
          if (instr_valid_i && ffs_any_s) begin
            state_r          <= S_ISSUE;
            op_r             <= op_i;
            mask_r           <= new_mask_s;
            n_r              <= new_cnt_s;
            k_r              <= '0;
            base_r           <= new_base_s;
            base_in_mask_r   <= new_mask_s[new_base_s];
            instr_ready_o    <= 1'b0;
            busy_o           <= 1'b1;
            beat_valid_o     <= 1'b1;
            beat_reg_addr_o  <= ffs_idx_s;
            beat_base_addr_o <= new_base_s;
            beat_offset_o    <= beat_off(op_i, new_cnt_s, '0);
            beat_is_load_o   <= (op_i == MR_POP) || (op_i == MR_LDM);
            beat_last_o      <= (new_cnt_s == ADDR_WIDTH'(1));
          end
        end
        S_ISSUE: begin
          if (beat_ready_i) begin
            mask_r <= mask_nxt_s;
            k_r    <= k_inc_s;
            if (beat_last_o) begin
              state_r      <= S_WB;
              beat_valid_o <= 1'b0;
              beat_last_o  <= 1'b0;
              // LDM that reloads its own base must not have that value overwritten
              wb_valid_o   <= !((op_r == MR_LDM) && base_in_mask_r);
              wb_reg_o     <= base_r;
              wb_offset_o  <= wb_off(op_r, n_r);
            end else begin
              beat_reg_addr_o <= ffs_idx_s;
              beat_offset_o   <= beat_off(op_r, n_r, k_inc_s);
              beat_last_o     <= ((k_r + ADDR_WIDTH'(2)) == n_r);
            end
          end
        end
        S_WB: begin
          state_r       <= S_IDLE;
          wb_valid_o    <= 1'b0;
          instr_ready_o <= 1'b1;
          busy_o        <= 1'b0;
        end
        default: begin
          state_r       <= S_IDLE;
          beat_valid_o  <= 1'b0;
          wb_valid_o    <= 1'b0;
          instr_ready_o <= 1'b1;
          busy_o        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_reg_addr_sequencer.sv
// Directed bench: expected beats/writebacks are queued when an instruction is
// driven and popped by a monitor when the DUT hands them over.
module tb_multi_reg_addr_sequencer;
  import multi_reg_addr_sequencer_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       instr_valid_i;
  logic       instr_ready_o;
  mr_op_e     op_i;
  logic [7:0] reg_list_i;
  logic       extra_reg_i;
  logic [3:0] base_reg_i;
  logic       flush_i;
  logic       beat_valid_o;
  logic       beat_ready_i;
  logic [3:0] beat_reg_addr_o;
  logic [3:0] beat_base_addr_o;
  logic [7:0] beat_offset_o;
  logic       beat_is_load_o;
  logic       beat_last_o;
  logic       wb_valid_o;
  logic [3:0] wb_reg_o;
  logic [7:0] wb_offset_o;
  logic       busy_o;

  multi_reg_addr_sequencer dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o), .op_i(op_i), .reg_list_i(reg_list_i),
    .extra_reg_i(extra_reg_i), .base_reg_i(base_reg_i), .flush_i(flush_i),
    .beat_valid_o(beat_valid_o), .beat_ready_i(beat_ready_i),
    .beat_reg_addr_o(beat_reg_addr_o), .beat_base_addr_o(beat_base_addr_o),
    .beat_offset_o(beat_offset_o), .beat_is_load_o(beat_is_load_o),
    .beat_last_o(beat_last_o), .wb_valid_o(wb_valid_o), .wb_reg_o(wb_reg_o),
    .wb_offset_o(wb_offset_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit         is_wb;
    logic [3:0] r;
    logic [3:0] base;
    logic [7:0] off;
    bit         ld;
    bit         last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   last_wb_cyc = 0;
  int   wb_cycles = 0;
  int   wb_before = 0;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_beat(input int r, input int base, input int off, input bit ld, input bit last);
    exp_t e;
    e.is_wb = 1'b0; e.r = 4'(r); e.base = 4'(base); e.off = 8'(off); e.ld = ld; e.last = last;
    sb.push_back(e);
  endtask

  task automatic exp_wb(input int r, input int off);
    exp_t e;
    e.is_wb = 1'b1; e.r = 4'(r); e.base = 4'd0; e.off = 8'(off); e.ld = 1'b0; e.last = 1'b0;
    sb.push_back(e);
  endtask

  // Monitor: scoreboard pops on handshakes and writeback pulses, counts WB cycles
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (busy_o && !beat_valid_o) wb_cycles++;
      if (beat_valid_o && beat_ready_i) begin
        if (sb.size() == 0) chk("unexpected_beat", {31'd0, beat_valid_o}, 32'd0);
        else begin
          mon_e = sb.pop_front();
          chk("beat_slot", {31'd0, mon_e.is_wb}, 32'd0);
          chk("beat_reg", {28'd0, beat_reg_addr_o}, {28'd0, mon_e.r});
          chk("beat_base", {28'd0, beat_base_addr_o}, {28'd0, mon_e.base});
          chk("beat_offset", {24'd0, beat_offset_o}, {24'd0, mon_e.off});
          chk("beat_is_load", {31'd0, beat_is_load_o}, {31'd0, mon_e.ld});
          chk("beat_last", {31'd0, beat_last_o}, {31'd0, mon_e.last});
        end
      end
      if (wb_valid_o) begin
        last_wb_cyc = cyc;
        if (sb.size() == 0) chk("unexpected_wb", {31'd0, wb_valid_o}, 32'd0);
        else begin
          mon_e = sb.pop_front();
          chk("wb_slot", {31'd0, mon_e.is_wb}, 32'd1);
          chk("wb_reg", {28'd0, wb_reg_o}, {28'd0, mon_e.r});
          chk("wb_offset", {24'd0, wb_offset_o}, {24'd0, mon_e.off});
        end
      end
    end
  end

  task automatic send(input mr_op_e op, input logic [7:0] list, input logic extra, input logic [3:0] base);
    @(posedge clk_i); #1;
    op_i = op; reg_list_i = list; extra_reg_i = extra; base_reg_i = base;
    instr_valid_i = 1'b1;
    acc_cyc = cyc;
    wb_before = wb_cycles;
    @(posedge clk_i); #1;
    instr_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while ((sb.size() != 0 || busy_o) && t < 200) begin
      @(posedge clk_i); #1;
      t++;
    end
    chk({tag, "_drained"}, sb.size(), 32'd0);
    chk({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_ready"}, {31'd0, instr_ready_o}, 32'd1);
  endtask

  initial begin
    rst_n_i = 1'b0; instr_valid_i = 1'b0; op_i = MR_PUSH; reg_list_i = 8'd0;
    extra_reg_i = 1'b0; base_reg_i = 4'd0; flush_i = 1'b0; beat_ready_i = 1'b1;
    #12;
    chk("rst_instr_ready", {31'd0, instr_ready_o}, 32'd1);
    chk("rst_beat_valid", {31'd0, beat_valid_o}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_offset", {24'd0, beat_offset_o}, 32'd0);
    rst_n_i = 1'b1;

    exp_beat(0, 13, -12, 0, 0); exp_beat(2, 13, -8, 0, 0); exp_beat(14, 13, -4, 0, 1);
    exp_wb(13, -12);
    send(MR_PUSH, 8'b0000_0101, 1'b1, 4'd0);
    wait_done("push");
    chk("push_wb_cycles", wb_cycles - wb_before, 32'd1);

    exp_beat(1, 13, 0, 1, 0); exp_beat(15, 13, 4, 1, 1);
    exp_wb(13, 8);
    send(MR_POP, 8'b0000_0010, 1'b1, 4'd7);
    wait_done("pop");

    // Base reloaded by LDM: WB cycle is occupied but no writeback pulse
    exp_beat(3, 3, 0, 1, 0); exp_beat(4, 3, 4, 1, 1);
    send(MR_LDM, 8'b0001_1000, 1'b0, 4'd3);
    wait_done("ldm_base_in_list");
    chk("ldm_wb_cycles", wb_cycles - wb_before, 32'd1);

    exp_beat(3, 0, 0, 1, 0); exp_beat(4, 0, 4, 1, 1);
    exp_wb(0, 8);
    send(MR_LDM, 8'b0001_1000, 1'b0, 4'd0);
    wait_done("ldm_base0");

    exp_beat(5, 0, 0, 0, 0); exp_beat(6, 0, 4, 0, 0); exp_beat(7, 0, 8, 0, 1);
    exp_wb(0, 12);
    send(MR_STM, 8'b1110_0000, 1'b0, 4'd0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    beat_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", {31'd0, beat_valid_o}, 32'd1);
      chk("stall_reg", {28'd0, beat_reg_addr_o}, 32'd7);
      chk("stall_offset", {24'd0, beat_offset_o}, 32'd8);
      chk("stall_last", {31'd0, beat_last_o}, 32'd1);
      @(posedge clk_i); #1;
    end
    beat_ready_i = 1'b1;
    wait_done("stm_stall");
    chk("stm_latency", last_wb_cyc - acc_cyc, 32'd7);

    send(MR_POP, 8'b0000_0000, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      chk("empty_ready", {31'd0, instr_ready_o}, 32'd1);
      chk("empty_beat_valid", {31'd0, beat_valid_o}, 32'd0);
      @(posedge clk_i); #1;
    end
    chk("empty_wb_cycles", wb_cycles - wb_before, 32'd0);

    // Flush after the first handshake of an eight-register PUSH
    exp_beat(0, 13, -32, 0, 0);
    send(MR_PUSH, 8'hFF, 1'b0, 4'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b1; beat_ready_i = 1'b0;
    @(posedge clk_i); #1;
    flush_i = 1'b0; beat_ready_i = 1'b1;
    chk("flush_beat_valid", {31'd0, beat_valid_o}, 32'd0);
    chk("flush_ready", {31'd0, instr_ready_o}, 32'd1);
    repeat (4) @(posedge clk_i);
    #1;
    wait_done("flush");
    chk("flush_wb_cycles", wb_cycles - wb_before, 32'd0);

    @(posedge clk_i); #1;
    op_i = MR_STM; reg_list_i = 8'h0F; base_reg_i = 4'd2;
    instr_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i); #1;
    instr_valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_accept_busy", {31'd0, busy_o}, 32'd0);
    chk("flush_accept_beat", {31'd0, beat_valid_o}, 32'd0);

    // Asynchronous reset in the middle of ISSUE
    exp_beat(0, 13, -32, 0, 0);
    send(MR_PUSH, 8'hFF, 1'b0, 4'd0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b0;
    #1;
    chk("arst_ready", {31'd0, instr_ready_o}, 32'd1);
    chk("arst_beat_valid", {31'd0, beat_valid_o}, 32'd0);
    chk("arst_busy", {31'd0, busy_o}, 32'd0);
    chk("arst_reg", {28'd0, beat_reg_addr_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    wait_done("arst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
